// File: rtl/pllclk_pkg.sv
// Shared state encoding, default cycle constants and sizing helper for the pllclk lock supervisor.
package pllclk_pkg;

    typedef enum logic [2:0] {
        S_PRST = 3'd0,
        S_WAIT = 3'd1,
        S_STAB = 3'd2,
        S_RUN  = 3'd3,
        S_FAIL = 3'd4
    } state_e;

    localparam int unsigned DEF_RST_PULSE_CYC    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
    localparam int unsigned DEF_MAX_RETRIES      = 3;
    localparam int unsigned DEF_SYNC_STAGES      = 2;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pllclk_sync.sv
// Multi-flop single-bit synchronizer with synchronous active-high reset.
module pllclk_sync
    import pllclk_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pllclk_lock_supervisor.sv
// Sequences PLL reset, qualifies the synchronized locked status and gates system reset release.
module pllclk_lock_supervisor
    import pllclk_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES
) (
    input  logic                               refclk_i,
    input  logic                               rst_i,
    input  logic                               pll_locked_i,
    input  logic                               soft_rst_i,
    input  logic                               clr_flags_i,
    output logic                               pll_rst_o,
    output logic                               sys_rst_o,
    output logic                               lock_ok_o,
    output logic                               fail_o,
    output logic                               lock_lost_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o
);

    localparam int unsigned CNT_MAX = max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
    logic                 lock_lost_q, lock_lost_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 sys_rst_q, sys_rst_d;
    logic                 lock_ok_q, lock_ok_d;
    logic                 fail_q, fail_d;
    logic                 locked_s;
    logic                 timeout_c;

    pllclk_sync #(
        .STAGES (SYNC_STAGES)
    ) u_locked_sync (
        .clk_i  (refclk_i),
        .rst_i  (rst_i),
        .d_i    (pll_locked_i),
        .q_o    (locked_s)
    );

    assign timeout_c = (state_q == S_WAIT) && !locked_s
                       && (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1));
    assign retry_inc = (retry_q == RETRY_W'(MAX_RETRIES)) ? retry_q : retry_q + RETRY_W'(1);

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q <= S_PRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; soft_rst overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_PRST: if (cnt_q == CNT_W'(RST_PULSE_CYC - 1)) state_d = S_WAIT;
            S_WAIT: begin
                if (locked_s) begin
                    state_d = S_STAB;
                end else if (timeout_c) begin
                    state_d = (retry_inc == RETRY_W'(MAX_RETRIES)) ? S_FAIL : S_PRST;
                end
            end
            S_STAB: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYC)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:  if (!locked_s) state_d = S_PRST;
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_PRST;
        endcase
        if (soft_rst_i) begin
            state_d = S_PRST;
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        pll_rst_d = (state_d == S_PRST);
        sys_rst_d = (state_d != S_RUN);
        lock_ok_d = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (soft_rst_i || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        retry_d = retry_q;
        if (soft_rst_i || ((state_d == S_RUN) && (state_q != S_RUN))) begin
            retry_d = '0;
        end else if (timeout_c) begin
            retry_d = retry_inc;
        end

        // A loss of lock in RUN wins over a simultaneous clear.
        lock_lost_d = lock_lost_q;
        if ((state_q == S_RUN) && !locked_s) begin
            lock_lost_d = 1'b1;
        end else if (clr_flags_i) begin
            lock_lost_d = 1'b0;
        end
    end

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            lock_ok_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            lock_ok_q   <= lock_ok_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign sys_rst_o   = sys_rst_q;
    assign lock_ok_o   = lock_ok_q;
    assign fail_o      = fail_q;
    assign lock_lost_o = lock_lost_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pllclk_lock_supervisor.sv
// Directed timing checks plus randomized stimulus against a dwell-time reference model.
module tb_pllclk_lock_supervisor;

    localparam int PULSE   = 4;
    localparam int TIMEOUT = 20;
    localparam int STABLE  = 8;
    localparam int RETRIES = 2;
    localparam int SYNC    = 2;

    localparam int P_PRST = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic       clr_flags = 1'b0;
    logic       pll_rst, sys_rst, lock_ok, fail, lock_lost;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, cycles spent in it, and a delay line for the synchronizer.
    int m_phase = P_PRST;
    int m_dwell = 0;
    int m_retry = 0;
    int m_lost  = 0;
    int m_hist [SYNC];

    always #5 clk = ~clk;

    pllclk_lock_supervisor #(
        .RST_PULSE_CYC    (PULSE),
        .LOCK_TIMEOUT_CYC (TIMEOUT),
        .LOCK_STABLE_CYC  (STABLE),
        .MAX_RETRIES      (RETRIES),
        .SYNC_STAGES      (SYNC)
    ) dut (
        .refclk_i     (clk),
        .rst_i        (rst),
        .pll_locked_i (pll_locked),
        .soft_rst_i   (soft_rst),
        .clr_flags_i  (clr_flags),
        .pll_rst_o    (pll_rst),
        .sys_rst_o    (sys_rst),
        .lock_ok_o    (lock_ok),
        .fail_o       (fail),
        .lock_lost_o  (lock_lost),
        .retry_cnt_o  (retry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic outsel(input int w);
        case (w)
            0:       return pll_rst;
            1:       return sys_rst;
            2:       return fail;
            default: return lock_ok;
        endcase
    endfunction

    // Count cycles until the selected output reaches val; expiry shows up as a wrong count.
    task automatic wait_for(input string tag, input int which, input logic val, input int exp_n);
        int n = 0;
        while (outsel(which) !== val && n < 200) begin
            step(1);
            n++;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"},   32'(pll_rst),   32'd1);
        check({tag, "_sys_rst"},   32'(sys_rst),   32'd1);
        check({tag, "_lock_ok"},   32'(lock_ok),   32'd0);
        check({tag, "_fail"},      32'(fail),      32'd0);
        check({tag, "_lock_lost"}, 32'(lock_lost), 32'd0);
        check({tag, "_retry"},     32'(retry_cnt), 32'd0);
    endtask

    // Compare after each edge, then advance the model with the inputs the next edge samples.
    always @(negedge clk) begin
        int ls, nxt, n;
        bit lost_set;
        check("model_pll_rst",   32'(pll_rst),   32'(m_phase == P_PRST));
        check("model_sys_rst",   32'(sys_rst),   32'(m_phase != P_RUN));
        check("model_lock_ok",   32'(lock_ok),   32'(m_phase == P_RUN));
        check("model_fail",      32'(fail),      32'(m_phase == P_FAIL));
        check("model_lock_lost", 32'(lock_lost), 32'(m_lost));
        check("model_retry",     32'(retry_cnt), 32'(m_retry));
        if (rst) begin
            m_phase = P_PRST;
            m_dwell = 0;
            m_retry = 0;
            m_lost  = 0;
            for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
        end else begin
            ls       = m_hist[SYNC-1];
            nxt      = m_phase;
            n        = m_dwell + 1;
            lost_set = (m_phase == P_RUN) && (ls == 0);
            case (m_phase)
                P_PRST: if (n == PULSE) nxt = P_WAIT;
                P_WAIT: begin
                    if (ls != 0) nxt = P_STAB;
                    else if (n == TIMEOUT) begin
                        m_retry++;
                        nxt = (m_retry == RETRIES) ? P_FAIL : P_PRST;
                    end
                end
                P_STAB: begin
                    if (ls == 0) nxt = P_WAIT;
                    else if (n == STABLE + 1) begin
                        nxt = P_RUN;
                        m_retry = 0;
                    end
                end
                P_RUN:  if (ls == 0) nxt = P_PRST;
                default: ;
            endcase
            if (soft_rst) begin
                nxt = P_PRST;
                m_retry = 0;
            end
            if (lost_set) m_lost = 1;
            else if (clr_flags) m_lost = 0;
            m_dwell = (nxt != m_phase || soft_rst) ? 0 : n;
            m_phase = nxt;
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = int'(pll_locked);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < SYNC; i++) m_hist[i] = 0;

        // Nominal bring-up
        step(3);
        rst = 1'b0;
        check_reset_vals("rst");
        wait_for("nom_prst_len", 0, 1'b0, PULSE);
        step(10);
        pll_locked = 1'b1;
        wait_for("nom_sys_rel", 1, 1'b0, 12);
        check("nom_lock_ok", 32'(lock_ok), 32'd1);
        check("nom_retry",   32'(retry_cnt), 32'd0);

        // Loss of lock in RUN, then clear the sticky flag
        pll_locked = 1'b0;
        step(2);
        check("lol_sys_still_low", 32'(sys_rst), 32'd0);
        step(1);
        check("lol_sys_rst",   32'(sys_rst),   32'd1);
        check("lol_flag",      32'(lock_lost), 32'd1);
        check("lol_pll_rst",   32'(pll_rst),   32'd1);
        wait_for("lol_prst_len", 0, 1'b0, PULSE);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("lol_clr", 32'(lock_lost), 32'd0);

        // Glitch during stabilization
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        wait_for("glitch_sys_rel", 1, 1'b0, 12);
        check("glitch_retry", 32'(retry_cnt), 32'd0);

        // soft_rst from RUN with lock held
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("softrun_pll_rst", 32'(pll_rst), 32'd1);
        check("softrun_lock_ok", 32'(lock_ok), 32'd0);
        check("softrun_sys_rst", 32'(sys_rst), 32'd1);
        wait_for("softrun_prst_len", 0, 1'b0, PULSE);
        wait_for("softrun_sys_rel", 1, 1'b0, 10);

        // Drop lock with a simultaneous clear, then time out twice into FAIL
        pll_locked = 1'b0;
        step(2);
        clr_flags = 1'b1;
        step(1);
        clr_flags = 1'b0;
        check("set_beats_clr", 32'(lock_lost), 32'd1);
        wait_for("to_prst1", 0, 1'b0, PULSE);
        wait_for("to_wait1", 0, 1'b1, TIMEOUT);
        check("to_retry1", 32'(retry_cnt), 32'd1);
        wait_for("to_prst2", 0, 1'b0, PULSE);
        wait_for("to_fail", 2, 1'b1, TIMEOUT);
        check("to_retry2",  32'(retry_cnt), 32'd2);
        check("to_pll_rst", 32'(pll_rst), 32'd0);
        step(50);
        check("fail_hold",         32'(fail),    32'd1);
        check("fail_hold_sys_rst", 32'(sys_rst), 32'd1);
        check("fail_hold_pll_rst", 32'(pll_rst), 32'd0);

        // soft_rst out of FAIL, then soft_rst coinciding with the final timeout
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("softfail_pll_rst", 32'(pll_rst),   32'd1);
        check("softfail_fail",    32'(fail),      32'd0);
        check("softfail_retry",   32'(retry_cnt), 32'd0);
        wait_for("sf_prst1", 0, 1'b0, PULSE);
        wait_for("sf_wait1", 0, 1'b1, TIMEOUT);
        check("sf_retry1", 32'(retry_cnt), 32'd1);
        wait_for("sf_prst2", 0, 1'b0, PULSE);
        step(TIMEOUT - 1);
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("soft_on_to_fail",  32'(fail),      32'd0);
        check("soft_on_to_retry", 32'(retry_cnt), 32'd0);
        check("soft_on_to_prst",  32'(pll_rst),   32'd1);
        wait_for("sot_prst", 0, 1'b0, PULSE);
        wait_for("sot_wait", 0, 1'b1, TIMEOUT);
        check("sot_retry", 32'(retry_cnt), 32'd1);

        // rst asserted mid-stabilization
        pll_locked = 1'b1;
        wait_for("stab_prst", 0, 1'b0, PULSE);
        step(4);
        check("stab_still_rst", 32'(sys_rst), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset_vals("midrst");
        wait_for("midrst_prst", 0, 1'b0, PULSE);
        wait_for("midrst_sys_rel", 1, 1'b0, 10);

        // Randomized soak against the model
        repeat (150) begin
            int hold;
            pll_locked = 1'($urandom_range(0, 3) != 0);
            hold = pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 35));
            for (int i = 0; i < hold; i++) begin
                soft_rst  = ($urandom_range(0, 199) == 0);
                clr_flags = ($urandom_range(0, 29) == 0);
                rst       = ($urandom_range(0, 499) == 0);
                step(1);
            end
        end
        soft_rst  = 1'b0;
        clr_flags = 1'b0;
        rst       = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
